// File: rtl/mem_stage.sv
// -----------------------------------------------------------------------------
// mem_stage
//
// Memory pipeline stage between execute and writeback.
//
// The stage takes the execute-stage result and, for loads and stores, issues a
// single-cycle request on the data-memory req/resp port. It then waits for the
// response, formats the load data and registers the writeback result.
//
// While a data-memory access is outstanding, o_mem_stall freezes all earlier
// stages. The registered writeback data (o_wb_data) also feeds the execute
// stage's mem-source forwarding path.
//
// Ports
//   clk, rst        clock; synchronous active-high reset
//   i_stall         stall from the other stages (excludes o_mem_stall)
//   i_valid         execute register holds a live instruction
//   i_alu_out       ALU result / effective address
//   i_store_data    rs2 data for stores
//   i_rd_addr       destination register
//   i_regf_we       instruction writes rd
//   i_mem_read      load
//   i_mem_write     store
//   i_funct3        access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
//   o_dmem_addr     word-aligned address
//   o_dmem_rmask    byte read mask; nonzero for one cycle = read request
//   o_dmem_wmask    byte write mask; nonzero for one cycle = write request
//   o_dmem_wdata    lane-shifted store data
//   i_dmem_rdata    read data, valid with i_dmem_resp
//   i_dmem_resp     access complete (earliest the cycle after the request)
//   o_mem_stall     stage busy; freeze all earlier stages
//   o_valid         one-cycle pulse per retiring instruction
//   o_rd_addr       registered rd
//   o_regf_we       registered write enable
//   o_wb_data       registered writeback data
//   o_misaligned    registered misaligned-access flag
//
// Configuration macro: MEM_STAGE_MISALIGN_CHECK_EN
//   defined   - misaligned H/HU/W accesses issue no request, do not stall,
//               retire with o_misaligned=1 and o_regf_we forced to 0.
//   undefined - the byte offset is forced to natural alignment and
//               o_misaligned is tied to 0.
// -----------------------------------------------------------------------------
module mem_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_stall,
    input  logic        i_valid,
    input  logic [31:0] i_alu_out,
    input  logic [31:0] i_store_data,
    input  logic [4:0]  i_rd_addr,
    input  logic        i_regf_we,
    input  logic        i_mem_read,
    input  logic        i_mem_write,
    input  logic [2:0]  i_funct3,
    output logic [31:0] o_dmem_addr,
    output logic [3:0]  o_dmem_rmask,
    output logic [3:0]  o_dmem_wmask,
    output logic [31:0] o_dmem_wdata,
    input  logic [31:0] i_dmem_rdata,
    input  logic        i_dmem_resp,
    output logic        o_mem_stall,
    output logic        o_valid,
    output logic [4:0]  o_rd_addr,
    output logic        o_regf_we,
    output logic [31:0] o_wb_data,
    output logic        o_misaligned
);

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_WAIT = 2'b01;
    localparam logic [1:0] ST_DONE = 2'b10;

    // Byte-lane mask for an access of the given size at byte offset off.
    function automatic logic [3:0] byte_mask(input logic [2:0] funct3,
                                             input logic [1:0] off);
        logic [3:0] m;
        case (funct3[1:0])
            2'b00:   m = 4'b0001 << off;
            2'b01:   m = 4'b0011 << off;
            default: m = 4'b1111;
        endcase
        return m;
    endfunction

    // Extract the addressed byte/half from the read word and extend it.
    // funct3[2] selects zero extension (BU/HU).
    function automatic logic [31:0] format_load(input logic [31:0] rdata,
                                                input logic [1:0]  off,
                                                input logic [2:0]  funct3);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (off)
            2'b00:   b = rdata[7:0];
            2'b01:   b = rdata[15:8];
            2'b10:   b = rdata[23:16];
            default: b = rdata[31:24];
        endcase
        h = off[1] ? rdata[31:16] : rdata[15:0];
        case (funct3[1:0])
            2'b00:   r = {{24{b[7] & ~funct3[2]}}, b};
            2'b01:   r = {{16{h[15] & ~funct3[2]}}, h};
            default: r = rdata;
        endcase
        return r;
    endfunction

    logic [1:0]  state_q, state_d;
    logic [31:0] ld_data_q, ld_data_d;
    logic        valid_q, valid_d;
    logic [4:0]  rd_q, rd_d;
    logic        we_q, we_d;
    logic [31:0] wb_q, wb_d;
    logic        mis_q, mis_d;

    logic        is_mem;
    logic        is_half;
    logic        is_word;
    logic [1:0]  off;
    logic        misaligned;
    logic        acc;
    logic        req;
    logic        advance;
    logic        load_wb;
    logic [3:0]  mask;
    logic [31:0] resp_fmt;

    assign is_mem  = i_mem_read | i_mem_write;
    assign is_half = (i_funct3[1:0] == 2'b01);
    assign is_word = i_funct3[1];

`ifdef MEM_STAGE_MISALIGN_CHECK_EN
    assign off        = i_alu_out[1:0];
    // Only a live memory instruction can be flagged.
    assign misaligned = i_valid & is_mem &
                        ((is_half & off[0]) | (is_word & (off != 2'b00)));
`else
    // Without the check, low address bits below the access size are ignored.
    assign off        = is_word ? 2'b00 :
                        (is_half ? {i_alu_out[1], 1'b0} : i_alu_out[1:0]);
    assign misaligned = 1'b0;
`endif

    assign acc  = i_valid & is_mem & ~misaligned;
    // The request lasts exactly one cycle: the IDLE cycle that sees the access.
    assign req  = ~rst & (state_q == ST_IDLE) & acc;
    assign mask = byte_mask(i_funct3, off);

    assign o_dmem_addr  = {i_alu_out[31:2], 2'b00};
    assign o_dmem_rmask = (req & i_mem_read)  ? mask : 4'b0000;
    assign o_dmem_wmask = (req & i_mem_write) ? mask : 4'b0000;
    assign o_dmem_wdata = i_store_data << {off, 3'b000};

    // The response cycle itself does not stall, so a single-wait access
    // costs exactly the request cycle plus the response cycle.
    assign o_mem_stall = ~rst & (req | ((state_q == ST_WAIT) & ~i_dmem_resp));
    assign advance     = ~o_mem_stall & ~i_stall;

    assign resp_fmt = format_load(i_dmem_rdata, off, i_funct3);
    assign load_wb  = i_valid & i_mem_read & ~misaligned;

    always_comb begin
        state_d   = state_q;
        ld_data_d = ld_data_q;
        case (state_q)
            ST_IDLE: begin
                if (acc) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (i_dmem_resp) begin
                    ld_data_d = resp_fmt;
                    state_d   = i_stall ? ST_DONE : ST_IDLE;
                end
            end
            ST_DONE: begin
                // Parked with captured data; any response here is stray.
                if (!i_stall) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        valid_d = 1'b0;
        rd_d    = rd_q;
        we_d    = we_q;
        wb_d    = wb_q;
        mis_d   = mis_q;
        if (advance) begin
            valid_d = i_valid;
            rd_d    = i_rd_addr;
            we_d    = i_regf_we & ~misaligned;
            mis_d   = misaligned;
            if (load_wb) begin
                // Retiring on the response cycle uses the live formatted
                // data; retiring out of DONE uses the captured copy.
                wb_d = (state_q == ST_WAIT) ? resp_fmt : ld_data_q;
            end else begin
                wb_d = i_alu_out;
            end
        end
    end

    // ---- MEM -> WB register boundary ----
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            valid_q <= 1'b0;
            rd_q    <= 5'd0;
            we_q    <= 1'b0;
            wb_q    <= 32'd0;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            rd_q    <= rd_d;
            we_q    <= we_d;
            wb_q    <= wb_d;
            mis_q   <= mis_d;
        end
    end

    // Captured load data is only read after it has been written.
    always_ff @(posedge clk) begin
        ld_data_q <= ld_data_d;
    end

    assign o_valid   = valid_q;
    assign o_rd_addr = rd_q;
    assign o_regf_we = we_q;
    assign o_wb_data = wb_q;
`ifdef MEM_STAGE_MISALIGN_CHECK_EN
    assign o_misaligned = mis_q;
`else
    assign o_misaligned = 1'b0;
`endif

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_stall;
    logic        i_valid;
    logic [31:0] i_alu_out;
    logic [31:0] i_store_data;
    logic [4:0]  i_rd_addr;
    logic        i_regf_we;
    logic        i_mem_read;
    logic        i_mem_write;
    logic [2:0]  i_funct3;
    logic [31:0] o_dmem_addr;
    logic [3:0]  o_dmem_rmask;
    logic [3:0]  o_dmem_wmask;
    logic [31:0] o_dmem_wdata;
    logic [31:0] i_dmem_rdata;
    logic        i_dmem_resp;
    logic        o_mem_stall;
    logic        o_valid;
    logic [4:0]  o_rd_addr;
    logic        o_regf_we;
    logic [31:0] o_wb_data;
    logic        o_misaligned;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_stage dut (
        .clk          (clk),
        .rst          (rst),
        .i_stall      (i_stall),
        .i_valid      (i_valid),
        .i_alu_out    (i_alu_out),
        .i_store_data (i_store_data),
        .i_rd_addr    (i_rd_addr),
        .i_regf_we    (i_regf_we),
        .i_mem_read   (i_mem_read),
        .i_mem_write  (i_mem_write),
        .i_funct3     (i_funct3),
        .o_dmem_addr  (o_dmem_addr),
        .o_dmem_rmask (o_dmem_rmask),
        .o_dmem_wmask (o_dmem_wmask),
        .o_dmem_wdata (o_dmem_wdata),
        .i_dmem_rdata (i_dmem_rdata),
        .i_dmem_resp  (i_dmem_resp),
        .o_mem_stall  (o_mem_stall),
        .o_valid      (o_valid),
        .o_rd_addr    (o_rd_addr),
        .o_regf_we    (o_regf_we),
        .o_wb_data    (o_wb_data),
        .o_misaligned (o_misaligned)
    );

    // ---------------- reference model (byte-level arithmetic) ----------------
    function automatic int m_size(input logic [2:0] f3);
        if (f3[1:0] == 2'b00) return 1;
        if (f3[1:0] == 2'b01) return 2;
        return 4;
    endfunction

    // Effective byte offset: address rounded down to a multiple of the size.
    function automatic int m_off(input logic [31:0] addr, input logic [2:0] f3);
        int a;
        int s;
        a = int'(addr % 4);
        s = m_size(f3);
        return (a / s) * s;
    endfunction

    function automatic logic [3:0] m_mask(input logic [2:0] f3, input int o);
        return 4'(((1 << m_size(f3)) - 1) << o);
    endfunction

    function automatic logic [31:0] m_wdata(input logic [31:0] sdata, input int o);
        logic [63:0] t;
        t = {32'h0, sdata} << (8 * o);
        return t[31:0];
    endfunction

    function automatic logic [31:0] m_load(input logic [31:0] rdata, input logic [2:0] f3,
                                           input int o);
        longint v;
        longint span;
        int     s;
        s = m_size(f3);
        v = longint'(rdata) >> (8 * o);
        if (s < 4) begin
            span = longint'(1) << (8 * s);
            v    = v % span;
            if (f3[2] == 1'b0 && v >= span / 2) v = v - span;
        end
        return 32'(v);
    endfunction

    // ---------------- transaction driver ----------------
    // kind: 0 = ALU op, 1 = load, 2 = store. lat = cycles from request to
    // response. hold = cycles of external stall after the response (or, for
    // an ALU op, before it may retire). Entered and left at posedge+1.
    task automatic run_txn(input int kind, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] sdata, input logic [31:0] rdata,
                           input int lat, input int hold, input logic [4:0] rd,
                           input logic we);
        int          o;
        logic [3:0]  er;
        logic [3:0]  ew;
        logic [31:0] exp_wb;
        logic        es;
        o      = m_off(addr, f3);
        er     = (kind == 1) ? m_mask(f3, o) : 4'h0;
        ew     = (kind == 2) ? m_mask(f3, o) : 4'h0;
        es     = (kind != 0);
        exp_wb = (kind == 1) ? m_load(rdata, f3, o) : addr;
        i_valid      = 1'b1;
        i_alu_out    = addr;
        i_store_data = sdata;
        i_rd_addr    = rd;
        i_regf_we    = we;
        i_mem_read   = (kind == 1);
        i_mem_write  = (kind == 2);
        i_funct3     = f3;
        i_dmem_resp  = 1'b0;
        i_stall      = (kind == 0) && (hold > 0);
        #1;
        checks++;
        if ({o_mem_stall, o_dmem_rmask, o_dmem_wmask} !== {es, er, ew}) begin
            errors++;
            $display("FAIL req_cycle stall/rmask/wmask got %b/%b/%b exp %b/%b/%b (addr %h f3 %b)",
                     o_mem_stall, o_dmem_rmask, o_dmem_wmask, es, er, ew, addr, f3);
        end
        if (kind != 0) begin
            checks++;
            if (o_dmem_addr !== {addr[31:2], 2'b00}) begin
                errors++;
                $display("FAIL dmem_addr got %h exp %h", o_dmem_addr, {addr[31:2], 2'b00});
            end
            if (kind == 2) begin
                checks++;
                if (o_dmem_wdata !== m_wdata(sdata, o)) begin
                    errors++;
                    $display("FAIL dmem_wdata got %h exp %h", o_dmem_wdata, m_wdata(sdata, o));
                end
            end
            for (int c = 1; c <= lat; c++) begin
                @(posedge clk);
                #1;
                i_dmem_resp  = (c == lat);
                i_dmem_rdata = (c == lat) ? rdata : $urandom;
                if (c == lat) i_stall = (hold > 0);
                es = (c != lat);
                #1;
                checks++;
                if ({o_mem_stall, o_dmem_rmask, o_dmem_wmask, o_valid} !== {es, 9'h0}) begin
                    errors++;
                    $display("FAIL wait_cycle %0d stall/rmask/wmask/valid got %b/%b/%b/%b exp %b/0000/0000/0",
                             c, o_mem_stall, o_dmem_rmask, o_dmem_wmask, o_valid, es);
                end
            end
            for (int h = 0; h < hold; h++) begin
                @(posedge clk);
                #1;
                // A stray response while parked must not disturb the result.
                i_dmem_resp  = 1'b1;
                i_dmem_rdata = $urandom;
                i_stall      = (h < hold - 1);
                #1;
                checks++;
                if ({o_mem_stall, o_dmem_rmask, o_dmem_wmask, o_valid} !== 10'h0) begin
                    errors++;
                    $display("FAIL done_cycle %0d stall/rmask/wmask/valid got %b/%b/%b/%b exp 0/0000/0000/0",
                             h, o_mem_stall, o_dmem_rmask, o_dmem_wmask, o_valid);
                end
            end
        end else begin
            for (int h = 0; h < hold; h++) begin
                @(posedge clk);
                #1;
                i_stall = (h < hold - 1);
                #1;
                checks++;
                if ({o_mem_stall, o_valid} !== 2'b00) begin
                    errors++;
                    $display("FAIL alu_hold %0d stall/valid got %b/%b exp 0/0", h, o_mem_stall, o_valid);
                end
            end
        end
        @(posedge clk);
        #1;
        i_dmem_resp = 1'b0;
        i_stall     = 1'b0;
        checks++;
        if ({o_valid, o_rd_addr, o_regf_we, o_misaligned} !== {1'b1, rd, we, 1'b0}) begin
            errors++;
            $display("FAIL retire valid/rd/we/mis got %b/%0d/%b/%b exp 1/%0d/%b/0",
                     o_valid, o_rd_addr, o_regf_we, o_misaligned, rd, we);
        end
        checks++;
        if (o_wb_data !== exp_wb) begin
            errors++;
            $display("FAIL retire wb_data got %h exp %h (kind %0d addr %h f3 %b)",
                     o_wb_data, exp_wb, kind, addr, f3);
        end
    endtask

    task automatic idle_cycle();
        i_valid     = 1'b0;
        i_mem_read  = 1'b0;
        i_mem_write = 1'b0;
        i_dmem_resp = 1'b0;
        i_stall     = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (o_valid !== 1'b0) begin
            errors++;
            $display("FAIL idle valid got %b exp 0", o_valid);
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst          = 1'b1;
        i_stall      = 1'b0;
        i_valid      = 1'b0;
        i_alu_out    = 32'h0;
        i_store_data = 32'h0;
        i_rd_addr    = 5'd0;
        i_regf_we    = 1'b0;
        i_mem_read   = 1'b0;
        i_mem_write  = 1'b0;
        i_funct3     = 3'b000;
        i_dmem_rdata = 32'h0;
        i_dmem_resp  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({o_valid, o_rd_addr, o_regf_we, o_wb_data, o_misaligned} !== 40'h0) begin
            errors++;
            $display("FAIL reset regs valid/rd/we/wb/mis got %b/%0d/%b/%h/%b exp all 0",
                     o_valid, o_rd_addr, o_regf_we, o_wb_data, o_misaligned);
        end
        checks++;
        if ({o_mem_stall, o_dmem_rmask, o_dmem_wmask, o_dmem_addr, o_dmem_wdata} !== 73'h0) begin
            errors++;
            $display("FAIL reset port stall/rmask/wmask/addr/wdata got %b/%b/%b/%h/%h exp all 0",
                     o_mem_stall, o_dmem_rmask, o_dmem_wmask, o_dmem_addr, o_dmem_wdata);
        end
        rst = 1'b0;
        #1;
        checks++;
        if ({o_valid, o_mem_stall, o_dmem_rmask, o_dmem_wmask} !== 10'h0) begin
            errors++;
            $display("FAIL post_reset valid/stall/masks got %b/%b/%b/%b exp 0",
                     o_valid, o_mem_stall, o_dmem_rmask, o_dmem_wmask);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_load();
        run_txn(1, 3'b000, 32'h0000_0103, 32'h0, 32'h80FF_FF11, 3, 0, 5'd7, 1'b1);
        checks++;
        if (o_wb_data !== 32'hFFFF_FF80) begin
            errors++;
            $display("FAIL lb_0x103 wb_data got %h exp ffffff80", o_wb_data);
        end
        idle_cycle();
        run_txn(1, 3'b101, 32'h0000_0102, 32'h0, 32'h80FF_1234, 1, 0, 5'd9, 1'b1);
        checks++;
        if (o_wb_data !== 32'h0000_80FF) begin
            errors++;
            $display("FAIL lhu_0x102 wb_data got %h exp 000080ff", o_wb_data);
        end
        idle_cycle();
    endtask

    task automatic test_store_back_to_back();
        run_txn(2, 3'b000, 32'h0000_0201, 32'h0000_00AB, 32'h0, 1, 0, 5'd0, 1'b0);
        run_txn(2, 3'b010, 32'h0000_0204, 32'hDEAD_BEEF, 32'h0, 2, 0, 5'd0, 1'b0);
        run_txn(1, 3'b001, 32'h0000_0206, 32'h0, 32'h8001_7FFF, 1, 0, 5'd3, 1'b1);
        run_txn(0, 3'b000, 32'h1234_5678, 32'h0, 32'h0, 0, 0, 5'd4, 1'b1);
        idle_cycle();
    endtask

    task automatic test_stall_in_response();
        run_txn(1, 3'b010, 32'h0000_0300, 32'h0, 32'hCAFE_F00D, 2, 3, 5'd12, 1'b1);
        run_txn(1, 3'b100, 32'h0000_0302, 32'h0, 32'h0099_0000, 1, 1, 5'd13, 1'b1);
        run_txn(0, 3'b000, 32'h0000_0ACE, 32'h0, 32'h0, 0, 2, 5'd14, 1'b1);
        idle_cycle();
    endtask

    task automatic test_reset_mid_access();
        i_valid     = 1'b1;
        i_alu_out   = 32'h0000_0400;
        i_mem_read  = 1'b1;
        i_mem_write = 1'b0;
        i_funct3    = 3'b010;
        i_rd_addr   = 5'd5;
        i_regf_we   = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        checks++;
        if ({o_mem_stall, o_dmem_rmask} !== 5'h0) begin
            errors++;
            $display("FAIL rst_in_wait stall/rmask got %b/%b exp 0/0000", o_mem_stall, o_dmem_rmask);
        end
        @(posedge clk);
        #1;
        rst        = 1'b0;
        i_valid    = 1'b0;
        i_mem_read = 1'b0;
        #1;
        checks++;
        if ({o_mem_stall, o_valid} !== 2'b00) begin
            errors++;
            $display("FAIL after_rst stall/valid got %b/%b exp 0/0", o_mem_stall, o_valid);
        end
        @(posedge clk);
        #1;
        i_dmem_resp  = 1'b1;
        i_dmem_rdata = 32'h7777_7777;
        #1;
        checks++;
        if ({o_mem_stall, o_dmem_rmask, o_valid} !== 6'h0) begin
            errors++;
            $display("FAIL late_resp stall/rmask/valid got %b/%b/%b exp 0", o_mem_stall, o_dmem_rmask, o_valid);
        end
        idle_cycle();
        run_txn(1, 3'b010, 32'h0000_0400, 32'h0, 32'h1357_9BDF, 2, 0, 5'd5, 1'b1);
        idle_cycle();
    endtask

    task automatic test_misaligned();
`ifdef MEM_STAGE_MISALIGN_CHECK_EN
        i_valid     = 1'b1;
        i_alu_out   = 32'h0000_0102;
        i_mem_read  = 1'b1;
        i_mem_write = 1'b0;
        i_funct3    = 3'b010;
        i_rd_addr   = 5'd6;
        i_regf_we   = 1'b1;
        i_stall     = 1'b0;
        #1;
        checks++;
        if ({o_mem_stall, o_dmem_rmask, o_dmem_wmask} !== 9'h0) begin
            errors++;
            $display("FAIL mis_lw stall/rmask/wmask got %b/%b/%b exp 0", o_mem_stall, o_dmem_rmask, o_dmem_wmask);
        end
        @(posedge clk);
        #1;
        checks++;
        if ({o_valid, o_misaligned, o_regf_we, o_rd_addr} !== {1'b1, 1'b1, 1'b0, 5'd6}) begin
            errors++;
            $display("FAIL mis_lw retire valid/mis/we/rd got %b/%b/%b/%0d exp 1/1/0/6",
                     o_valid, o_misaligned, o_regf_we, o_rd_addr);
        end
        i_mem_read  = 1'b0;
        i_mem_write = 1'b1;
        i_alu_out   = 32'h0000_0203;
        i_funct3    = 3'b001;
        #1;
        checks++;
        if ({o_mem_stall, o_dmem_wmask} !== 5'h0) begin
            errors++;
            $display("FAIL mis_sh stall/wmask got %b/%b exp 0/0000", o_mem_stall, o_dmem_wmask);
        end
        @(posedge clk);
        #1;
        checks++;
        if ({o_valid, o_misaligned} !== 2'b11) begin
            errors++;
            $display("FAIL mis_sh retire valid/mis got %b/%b exp 1/1", o_valid, o_misaligned);
        end
        run_txn(1, 3'b001, 32'h0000_0102, 32'h0, 32'hABCD_0000, 1, 0, 5'd8, 1'b1);
`else
        run_txn(1, 3'b010, 32'h0000_0102, 32'h0, 32'h0BAD_F00D, 1, 0, 5'd6, 1'b1);
        checks++;
        if (o_wb_data !== 32'h0BAD_F00D) begin
            errors++;
            $display("FAIL unchecked_lw wb_data got %h exp 0badf00d", o_wb_data);
        end
`endif
        idle_cycle();
    endtask

    task automatic test_random();
        logic [2:0]  ld_f3 [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        int          kind;
        logic [2:0]  f3;
        logic [31:0] addr;
        int          hold;
        for (int n = 0; n < 60; n++) begin
            kind = $urandom_range(0, 2);
            f3   = (kind == 2) ? 3'($urandom_range(0, 2)) : ld_f3[$urandom_range(0, 4)];
            addr = $urandom;
`ifdef MEM_STAGE_MISALIGN_CHECK_EN
            addr[1:0] = 2'(m_off(addr, f3));
`endif
            hold = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
            run_txn(kind, f3, addr, $urandom, $urandom, $urandom_range(1, 4), hold,
                    5'($urandom), 1'($urandom));
            if ($urandom_range(0, 2) == 0) idle_cycle();
        end
        idle_cycle();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_load();
        test_store_back_to_back();
        test_stall_in_response();
        test_reset_mid_access();
        test_misaligned();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
